// File: rtl/pad_frame_writer_pkg.sv
// Shared types and geometry for the padded frame buffer writer.
// Optional feature macro: BORDER_CLEAR_EN (border rewrite before every frame).
package pad_frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LOAD,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      SEG_TOP,
      SEG_BOT,
      SEG_SIDE
   } seg_e;

   localparam int DEF_IMG_W    = 64;
   localparam int DEF_IMG_H    = 64;
   localparam int PAD_W        = DEF_IMG_W + 2;
   localparam int PAD_H        = DEF_IMG_H + 2;
   localparam int BORDER_CELLS = 2 * PAD_W + 2 * DEF_IMG_H;

   function automatic int border_cells(input int img_w, input int img_h);
      return 2 * (img_w + 2) + 2 * img_h;
   endfunction

endpackage

// File: rtl/pad_frame_writer_if.sv
// Pixel stream, buffer write port and status of the padded frame writer.
// master = stream source / buffer owner, slave = the writer itself.
interface pad_frame_writer_if #(
   parameter int PIX_W = 8,
   parameter int IDX_W = 7
) ();

   logic             start;
   logic             s_valid;
   logic             s_ready;
   logic [PIX_W-1:0] s_pixel;
   logic             mem_we;
   logic [IDX_W-1:0] mem_row;
   logic [IDX_W-1:0] mem_col;
   logic [PIX_W-1:0] mem_wdata;
   logic             busy;
   logic             frame_done;

   modport master (
      output start, s_valid, s_pixel,
      input  s_ready, mem_we, mem_row, mem_col, mem_wdata, busy, frame_done
   );

   modport slave (
      input  start, s_valid, s_pixel,
      output s_ready, mem_we, mem_row, mem_col, mem_wdata, busy, frame_done
   );

endinterface

// File: rtl/pad_border_walker.sv
// Walks the one-pixel border: row 0, last row, then (r,0)/(r,last col) pairs.
// Advances on step; last flags the final cell and the next step wraps to (0,0).
module pad_border_walker
   import pad_frame_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int IDX_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             step,
   output logic [IDX_W-1:0] row,
   output logic [IDX_W-1:0] col,
   output logic             last
);

   localparam int NB    = border_cells(IMG_W, IMG_H);
   localparam int CNT_W = $clog2(NB);
   localparam logic [IDX_W-1:0] COL_END  = IDX_W'(IMG_W + 1);
   localparam logic [IDX_W-1:0] ROW_END  = IDX_W'(IMG_H + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);

   seg_e             seg_q, seg_d;
   logic [IDX_W-1:0] row_q, row_d;
   logic [IDX_W-1:0] col_q, col_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign last = (cnt_q == CNT_LAST);
   assign row  = row_q;
   assign col  = col_q;

   always_comb begin
      seg_d = seg_q;
      row_d = row_q;
      col_d = col_q;
      cnt_d = cnt_q;
      if (clr || (step && last)) begin
         seg_d = SEG_TOP;
         row_d = '0;
         col_d = '0;
         cnt_d = '0;
      end else if (step) begin
         cnt_d = cnt_q + 1'b1;
         case (seg_q)
            SEG_TOP: begin
               if (col_q == COL_END) begin
                  seg_d = SEG_BOT;
                  row_d = ROW_END;
                  col_d = '0;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
            SEG_BOT: begin
               if (col_q == COL_END) begin
                  seg_d = SEG_SIDE;
                  row_d = IDX_W'(1);
                  col_d = '0;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
            SEG_SIDE: begin
               // Left edge then right edge of the same row before moving down.
               if (col_q == '0) begin
                  col_d = COL_END;
               end else begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
               end
            end
            default: seg_d = SEG_TOP;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q <= SEG_TOP;
         row_q <= '0;
         col_q <= '0;
         cnt_q <= '0;
      end else begin
         seg_q <= seg_d;
         row_q <= row_d;
         col_q <= col_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pad_frame_writer.sv
// Loads a raster pixel stream into a zero-padded frame buffer, interior at (r+1,c+1).
// BORDER_CLEAR_EN adds a border-clear pass before each frame; writes are registered (1 cycle).
module pad_frame_writer
   import pad_frame_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int PIX_W = 8,
   parameter int IDX_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   pad_frame_writer_if.slave bus
);

   localparam logic [IDX_W-1:0] C_LAST = IDX_W'(IMG_W - 1);
   localparam logic [IDX_W-1:0] R_LAST = IDX_W'(IMG_H - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] r_q, r_d;
   logic [IDX_W-1:0] c_q, c_d;
   logic             mem_we_q, mem_we_d;
   logic [IDX_W-1:0] mem_row_q, mem_row_d;
   logic [IDX_W-1:0] mem_col_q, mem_col_d;
   logic [PIX_W-1:0] mem_wdata_q, mem_wdata_d;
   logic             frame_done_q, frame_done_d;

`ifdef BORDER_CLEAR_EN
   logic             brd_clr;
   logic             brd_step;
   logic             brd_last;
   logic [IDX_W-1:0] brd_row;
   logic [IDX_W-1:0] brd_col;
   // Set once the final border write has been issued; CLEAR then hands over to LOAD.
   logic             fin_q, fin_d;

   pad_border_walker #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .IDX_W (IDX_W)
   ) u_walker (
      .clk  (clk),
      .rst  (rst),
      .clr  (brd_clr),
      .step (brd_step),
      .row  (brd_row),
      .col  (brd_col),
      .last (brd_last)
   );
`endif

   always_comb begin
      state_d      = state_q;
      r_d          = r_q;
      c_d          = c_q;
      mem_we_d     = 1'b0;
      mem_row_d    = mem_row_q;
      mem_col_d    = mem_col_q;
      mem_wdata_d  = mem_wdata_q;
      frame_done_d = 1'b0;
`ifdef BORDER_CLEAR_EN
      brd_clr  = 1'b0;
      brd_step = 1'b0;
      fin_d    = fin_q;
`endif
      case (state_q)
         ST_IDLE: begin
`ifdef BORDER_CLEAR_EN
            brd_clr = !bus.start;
`endif
            if (bus.start) begin
               r_d = '0;
               c_d = '0;
`ifdef BORDER_CLEAR_EN
               // First border cell is issued on the start edge so the clear pass
               // fully precedes LOAD with no overlap.
               state_d     = ST_CLEAR;
               mem_we_d    = 1'b1;
               mem_row_d   = brd_row;
               mem_col_d   = brd_col;
               mem_wdata_d = '0;
               brd_step    = 1'b1;
               fin_d       = 1'b0;
`else
               state_d = ST_LOAD;
`endif
            end
         end
         ST_CLEAR: begin
`ifdef BORDER_CLEAR_EN
            if (fin_q) begin
               state_d = ST_LOAD;
               r_d     = '0;
               c_d     = '0;
            end else begin
               mem_we_d    = 1'b1;
               mem_row_d   = brd_row;
               mem_col_d   = brd_col;
               mem_wdata_d = '0;
               brd_step    = 1'b1;
               fin_d       = brd_last;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         ST_LOAD: begin
            if (bus.s_valid) begin
               mem_we_d    = 1'b1;
               mem_row_d   = r_q + 1'b1;
               mem_col_d   = c_q + 1'b1;
               mem_wdata_d = bus.s_pixel;
               if (c_q == C_LAST) begin
                  c_d = '0;
                  if (r_q == R_LAST) begin
                     r_d          = '0;
                     state_d      = ST_DONE;
                     frame_done_d = 1'b1;
                  end else begin
                     r_d = r_q + 1'b1;
                  end
               end else begin
                  c_d = c_q + 1'b1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         r_q          <= '0;
         c_q          <= '0;
         mem_we_q     <= 1'b0;
         mem_row_q    <= '0;
         mem_col_q    <= '0;
         mem_wdata_q  <= '0;
         frame_done_q <= 1'b0;
`ifdef BORDER_CLEAR_EN
         fin_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         r_q          <= r_d;
         c_q          <= c_d;
         mem_we_q     <= mem_we_d;
         mem_row_q    <= mem_row_d;
         mem_col_q    <= mem_col_d;
         mem_wdata_q  <= mem_wdata_d;
         frame_done_q <= frame_done_d;
`ifdef BORDER_CLEAR_EN
         fin_q        <= fin_d;
`endif
      end
   end

   assign bus.s_ready    = (state_q == ST_LOAD);
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_row    = mem_row_q;
   assign bus.mem_col    = mem_col_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_pad_frame_writer.sv
// Scoreboard bench for pad_frame_writer: stimulus pushes expected writes, a negedge
// monitor pops and compares every presented write. Honours BORDER_CLEAR_EN.
module tb_pad_frame_writer;

   localparam int W  = 64;
   localparam int H  = 64;
   localparam int PW = 8;
   localparam int IW = 7;

   typedef struct {
      logic [IW-1:0] row;
      logic [IW-1:0] col;
      logic [PW-1:0] data;
      logic          done;
      logic          border;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pad_frame_writer_if #(.PIX_W(PW), .IDX_W(IW)) bus ();

   pad_frame_writer #(
      .IMG_W (W),
      .IMG_H (H),
      .PIX_W (PW),
      .IDX_W (IW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   exp_t q[$];
   int   checks   = 0;
   int   errors   = 0;
   int   done_cnt = 0;
   int   brd_wr   = 0;
   int   pidx     = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic push(input int r, input int c, input int d, input bit dn, input bit brd);
      exp_t e;
      e.row    = IW'(r);
      e.col    = IW'(c);
      e.data   = PW'(d);
      e.done   = dn;
      e.border = brd;
      q.push_back(e);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.frame_done) done_cnt++;
         if (bus.mem_we) begin
            if (bus.mem_row == 0 || bus.mem_row == IW'(H + 1) ||
                bus.mem_col == 0 || bus.mem_col == IW'(W + 1)) brd_wr++;
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got r=%0d c=%0d d=%0d, none expected",
                        bus.mem_row, bus.mem_col, bus.mem_wdata);
            end else begin
               e = q.pop_front();
               if (bus.mem_row !== e.row || bus.mem_col !== e.col || bus.mem_wdata !== e.data ||
                   bus.frame_done !== e.done || (e.border && bus.s_ready !== 1'b0)) begin
                  errors++;
                  $display("FAIL write: got r=%0d c=%0d d=%0d done=%0d rdy=%0d expected r=%0d c=%0d d=%0d done=%0d brd=%0d",
                           bus.mem_row, bus.mem_col, bus.mem_wdata, bus.frame_done, bus.s_ready,
                           e.row, e.col, e.data, e.done, e.border);
               end
            end
         end else if (bus.frame_done) begin
            checks++;
            errors++;
            $display("FAIL done_without_write: got frame_done=1 with mem_we=0, expected both together");
         end
      end
   end

   task automatic push_border();
`ifdef BORDER_CLEAR_EN
      for (int c = 0; c < W + 2; c++) push(0, c, 0, 1'b0, 1'b1);
      for (int c = 0; c < W + 2; c++) push(H + 1, c, 0, 1'b0, 1'b1);
      for (int r = 1; r <= H; r++) begin
         push(r, 0, 0, 1'b0, 1'b1);
         push(r, W + 1, 0, 1'b0, 1'b1);
      end
`endif
   endtask

   // Returns #1 after the edge where s_ready should first be seen high.
   task automatic start_frame();
      pidx = 0;
      push_border();
      @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
`ifdef BORDER_CLEAR_EN
      begin
         int n = 0;
         while (!bus.s_ready && n < 400) begin
            @(posedge clk);
            #1;
            n++;
         end
         check("clear_cycles_before_ready", n, 260);
      end
`else
      check("ready_one_cycle_after_start", bus.s_ready, 1);
`endif
   endtask

   // pat 0: continuous valid; pat 1: valid pattern 1,0,0,1 repeating.
   task automatic send(input int npix, input int pat, input int start_at, input int seed);
      int acc = 0;
      int cyc = 0;
      bit v;
      while (acc < npix) begin
         v = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         bus.s_valid = v;
         bus.s_pixel = PW'((pidx + seed) % 256);
         bus.start   = (cyc == start_at);
         if (v) begin
            push(pidx / W + 1, pidx % W + 1, (pidx + seed) % 256, pidx == W * H - 1, 1'b0);
            pidx++;
            acc++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.s_valid = 1'b0;
      bus.start   = 1'b0;
   endtask

   // Called #1 after the final-pixel edge: DONE cycle, then IDLE with start ignored.
   task automatic finish_frame(input int frames);
      check("ready_low_in_done", bus.s_ready, 0);
      check("busy_in_done", bus.busy, 1);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      check("busy_low_after_done", bus.busy, 0);
      repeat (3) @(posedge clk);
      #1;
      check("ready_low_idle", bus.s_ready, 0);
      check("frame_done_count", done_cnt, frames);
      check("queue_drained", q.size(), 0);
   endtask

   task automatic check_reset_outputs();
      check("rst_s_ready", bus.s_ready, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_frame_done", bus.frame_done, 0);
      check("rst_mem_row", bus.mem_row, 0);
      check("rst_mem_col", bus.mem_col, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start   = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_pixel = 8'hA5;
      #22;
      check_reset_outputs();
      bus.start   = 1'b0;
      bus.s_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;

      // Stream ignored in IDLE
      bus.s_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.s_valid = 1'b0;
      check("idle_ready_low", bus.s_ready, 0);

      // Frame 1: continuous, stray start in LOAD and in DONE
      start_frame();
      send(W * H, 0, 100, 0);
      finish_frame(1);

      // Frame 2: stalled stream
      start_frame();
      send(W * H, 1, -1, 7);
      finish_frame(2);

      // Frame 3: abandoned by reset after 1000 pixels
      start_frame();
      send(1000, 0, -1, 3);
      @(negedge clk);
      #1 rst = 1'b1;
      #2;
      check_reset_outputs();
      check("queue_empty_at_reset", q.size(), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Frame 4: restart from (0,0)
      start_frame();
      send(W * H, 0, -1, 9);
      finish_frame(3);

`ifdef BORDER_CLEAR_EN
      check("border_write_total", brd_wr, 4 * 260);
`else
      check("border_write_total", brd_wr, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
